// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, oversample tick points
// and default frame geometry, used by both the receiver and transmitter.
package uart_pkg;

  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;

  // Tick index of the start-bit midpoint and of a full bit time,
  // counted in 16x-oversample pulses.
  localparam int TICK_MID  = 7;
  localparam int TICK_LAST = 15;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    RX_PARITY = 3'd4,
`endif
    RX_STOP   = 3'd3
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit.
// Ports: clk, rst_n (async low), d_i (async in), q_o (synchronised out).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= {2{RST_VAL}};
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx_oversample.sv
// UART receiver, 16x oversampled: start, DBIT data (LSB first), stop.
// Ports: clk, reset (async low), s_tick (16x enable), rx (serial in),
//   dout (last word), rx_done_tick (1-clk pulse), frame_err (stop low),
//   parity_err when UART_RX_PARITY_EN is defined (adds a parity bit).
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  // s is 4 bits; it widens only when a two-stop-bit setting
  // needs to count past 15 in the stop state.
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  typedef logic [SW-1:0] tick_t;

  localparam tick_t      S_MID  = tick_t'(TICK_MID);
  localparam tick_t      S_LAST = tick_t'(TICK_LAST);
  localparam tick_t      S_STOP = tick_t'(SB_TICK - 1);
  localparam logic [2:0] N_LAST = 3'(DBIT - 1);

  logic rx_s;

  rx_state_e       state_q, state_d;
  tick_t           s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic            pbit_q, pbit_d;
  logic            perr_q, perr_d;
`endif

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(reset),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RX_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbit_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pbit_q  <= pbit_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    pbit_d  = pbit_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      RX_IDLE: begin
        // Falling edge needs no tick; s starts at the next tick.
        if (!rx_s) begin
          state_d = RX_START;
          s_d     = '0;
        end
      end
      RX_START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = RX_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = RX_IDLE;
            end
          end else begin
            s_d = s_q + tick_t'(1);
          end
        end
      end
      RX_DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = RX_PARITY;
`else
              state_d = RX_STOP;
`endif
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + tick_t'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            pbit_d  = rx_s;
            state_d = RX_STOP;
          end else begin
            s_d = s_q + tick_t'(1);
          end
        end
      end
`endif
      RX_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            state_d = RX_IDLE;
            s_d     = '0;
            done_d  = 1'b1;
            dout_d  = b_q;
            ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            // Even: data plus parity must hold an even count of ones.
            perr_d  = (^b_q) ^ pbit_q ^ PARITY_ODD;
`endif
          end else begin
            s_d = s_q + tick_t'(1);
          end
        end
      end
      default: begin
        state_d = RX_IDLE;
        s_d     = '0;
      end
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample (DBIT=8, SB_TICK=16).
// s_tick fires every 4 clk; frames are driven a whole tick at a time.
module tb_uart_rx_oversample;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
  logic       got_p[$];
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int tcnt    = 0;

  logic [7:0] got_d[$];
  logic       got_f[$];

  uart_rx_oversample dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx          (rx),
    .dout        (dout),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tcnt   = tcnt + 1;
    s_tick = (tcnt % 4 == 0);
  end

  // Every clk with rx_done_tick high logs one frame, so a stretched
  // pulse shows up as an extra entry.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      got_d.push_back(dout);
      got_f.push_back(frame_err);
`ifdef UART_RX_PARITY_EN
      got_p.push_back(parity_err);
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
      #1;
    end
  endtask

  task automatic bitv(input logic v, input int n);
    rx = v;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input int stop_n);
    bitv(1'b0, 16);
    for (int i = 0; i < 8; i++) bitv(d[i], 16);
`ifdef UART_RX_PARITY_EN
    bitv((^d) ^ par_flip, 16);
`endif
    bitv(stop_v, stop_n);
    rx = 1'b1;
  endtask

  task automatic pop_frame(input string tag, input logic [7:0] d,
                           input logic f);
    logic [7:0] gd;
    logic       gf;
    gd = 8'h00;
    gf = 1'b0;
    if (got_d.size() > 0) begin
      gd = got_d.pop_front();
      gf = got_f.pop_front();
    end
    chk({tag, "_dout"}, 32'(gd), 32'(d));
    chk({tag, "_ferr"}, 32'(gf), 32'(f));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_done", 32'(rx_done_tick), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    reset = 1'b1;
    tick(4);

    send_frame(8'h55, 1'b1, 16);
    tick(4);
    chk("f55_cnt", 32'(got_d.size()), 32'd1);
    pop_frame("f55", 8'h55, 1'b0);

    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(20);
    chk("glitch_cnt", 32'(got_d.size()), 32'd0);
    chk("glitch_dout", 32'(dout), 32'h55);

    // Stop held low past its midpoint only, so the re-armed start
    // sees a high line at its own midpoint and is rejected.
    send_frame(8'hA3, 1'b0, 10);
    tick(10);
    chk("fa3_cnt", 32'(got_d.size()), 32'd1);
    pop_frame("fa3", 8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1, 16);
    tick(4);
    chk("f0f_cnt", 32'(got_d.size()), 32'd1);
    pop_frame("f0f", 8'h0F, 1'b0);

    bitv(1'b0, 16);
    for (int i = 0; i < 4; i++) bitv(1'b1, 16);
    bitv(1'b1, 5);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick(11 + 3 * 16 + 16);
    chk("rstmid_cnt", 32'(got_d.size()), 32'd0);
    chk("rstmid_dout", 32'(dout), 32'h00);
    send_frame(8'h3C, 1'b1, 16);
    tick(4);
    chk("f3c_cnt", 32'(got_d.size()), 32'd1);
    pop_frame("f3c", 8'h3C, 1'b0);

    send_frame(8'h01, 1'b1, 16);
    send_frame(8'h80, 1'b1, 16);
    tick(4);
    chk("b2b_cnt", 32'(got_d.size()), 32'd2);
    pop_frame("b2b0", 8'h01, 1'b0);
    pop_frame("b2b1", 8'h80, 1'b0);

`ifdef UART_RX_PARITY_EN
    got_p.delete();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 16);
    tick(4);
    chk("par0_cnt", 32'(got_p.size()), 32'd1);
    chk("par0_err", 32'(parity_err), 32'h1);
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, 16);
    tick(4);
    chk("par1_cnt", 32'(got_p.size()), 32'd2);
    chk("par1_err", 32'(parity_err), 32'h0);
    pop_frame("par0", 8'h07, 1'b0);
    pop_frame("par1", 8'h07, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 SHALL have parameter DBIT, default 8: number of data bits per frame (5..8).
REQ-002 SHALL have parameter SB_TICK, default 16: stop-bit length in s_tick pulses (16 = 1 stop bit, 32 = 2).
REQ-003 SHALL have port clk, input, 1: single system clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port s_tick, input, 1: 16x-oversample enable pulse, one clk wide, from the baud rate generator.
REQ-006 SHALL have port rx, input, 1: asynchronous serial line, idle high.
REQ-007 SHALL have port dout, output, DBIT: last received data word, LSB first on the line.
REQ-008 SHALL have port rx_done_tick, output, 1: one-clk pulse when a frame completes and dout is valid.
REQ-009 SHALL have port frame_err, output, 1: registered flag, valid with rx_done_tick; 1 = stop bit sampled low.

Function
REQ-010 SHALL pass rx through a two-flop synchroniser preset to 1; all decisions use the synchronised value (2-clk input latency).
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP (plus PARITY when enabled), with 4-bit tick counter s and 3-bit bit counter n.
REQ-012 IDLE: synchronised rx = 0 -> START, s = 0; s_tick is not required for this transition.
REQ-013 START: on s_tick with s = 7, rx = 0 -> DATA, s = 0, n = 0; rx = 1 -> IDLE (glitch rejected, no pulse); otherwise s increments.
REQ-014 DATA: on s_tick with s = 15, shift rx into MSB of shift register (right shift), s = 0; after n = DBIT-1 -> STOP (or PARITY), else n increments.
REQ-015 STOP: on s_tick with s = SB_TICK-1, sample rx, assert rx_done_tick for exactly one clk, load dout from shift register, set frame_err = ~rx, -> IDLE.
REQ-016 SHALL keep dout and frame_err stable between rx_done_tick pulses.
REQ-017 s_tick pulses SHALL be the only advance for s; clk cycles without s_tick SHALL hold s, n and state (except IDLE->START).
REQ-018 A frame whose stop bit is low SHALL still complete (rx_done_tick = 1, frame_err = 1); a subsequent low line is treated as a new start bit.
REQ-019 For DBIT < 8, received bits SHALL be right-aligned in dout.

Reset
REQ-020 reset = 0 SHALL immediately force state IDLE, s = 0, n = 0, shift register 0, dout 0, rx_done_tick 0, frame_err 0, parity_err 0, synchroniser 1.
REQ-021 Reset asserted mid-frame SHALL discard the partial frame with no rx_done_tick; release is synchronous to clk and resumes in IDLE.

Configuration
REQ-022 Macro UART_RX_PARITY_EN defined: SHALL add state PARITY after DATA (one bit, sampled at s = 15), parameter PARITY_ODD (default 0 = even), and output parity_err, 1 bit, valid with rx_done_tick.
REQ-023 Macro UART_RX_PARITY_EN undefined: SHALL have no PARITY state, no parity_err port, frame = start + DBIT + stop.

Structure
REQ-024 State encodings, tick-count constants (7, 15) and default DBIT/SB_TICK SHALL live in shared package uart_pkg, also used by the transmitter.
REQ-025 The two-flop synchroniser SHALL be a separate sub-module sync_2ff (1-bit, reset value parameter).

Verification
REQ-026 Frame 0x55, 16 s_tick per bit, stop high -> one rx_done_tick, dout = 0x55, frame_err = 0.
REQ-027 rx low for 4 ticks then high -> state returns to IDLE, no rx_done_tick, dout unchanged.
REQ-028 Frame 0xA3 with stop bit held low -> rx_done_tick = 1, dout = 0xA3, frame_err = 1; next valid 0x0F frame -> dout = 0x0F, frame_err = 0.
REQ-029 Reset pulsed low during bit 4 of frame 0xFF -> no rx_done_tick, dout = 0x00; next frame 0x3C received correctly.
REQ-030 Back-to-back frames 0x01, 0x80 with no idle gap -> two rx_done_tick pulses, dout 0x01 then 0x80.
REQ-031 With UART_RX_PARITY_EN, even parity, frame 0x07 with parity bit 0 -> parity_err = 1; with parity bit 1 -> parity_err = 0.
